// File: rtl/traffic_phase_scheduler_pkg.sv
// Shared types and default timing for the intersection phase scheduler.
package traffic_pkg;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALL_RED1  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALL_RED2  = 3'd5,
    PED_WALK  = 3'd6
  } phase_t;

  typedef enum logic {NS = 1'b0, EW = 1'b1} dir_t;
  typedef enum logic {A = 1'b0, B = 1'b1} ped_t;

  typedef struct packed {
    logic ns_r;
    logic ns_g;
    logic ew_r;
    logic ew_g;
    logic walk_a;
    logic walk_b;
  } lamps_t;

  localparam int DEF_TICK_DIV  = 100000000;
  localparam int DEF_G_TIME    = 30;
  localparam int DEF_G_MIN     = 2;
  localparam int DEF_G_MAX     = 60;
  localparam int DEF_STEP      = 2;
  localparam int DEF_Y_TIME    = 3;
  localparam int DEF_AR_TIME   = 2;
  localparam int DEF_WALK_TIME = 6;

  localparam lamps_t LAMPS_RST = '{ns_r: 1'b0, ns_g: 1'b1, ew_r: 1'b1, ew_g: 1'b0,
                                   walk_a: 1'b0, walk_b: 1'b0};

  // Yellow is shown as red+green on the RGB heads.
  function automatic lamps_t lamps_for(phase_t ph, ped_t grant);
    lamps_t l;
    l = '{ns_r: 1'b1, ns_g: 1'b0, ew_r: 1'b1, ew_g: 1'b0, walk_a: 1'b0, walk_b: 1'b0};
    case (ph)
      NS_GREEN:  begin l.ns_r = 1'b0; l.ns_g = 1'b1; end
      NS_YELLOW: l.ns_g = 1'b1;
      EW_GREEN:  begin l.ew_r = 1'b0; l.ew_g = 1'b1; end
      EW_YELLOW: l.ew_g = 1'b1;
      PED_WALK:  begin l.walk_a = (grant == A); l.walk_b = (grant == B); end
      default:   ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_phase_scheduler_if.sv
// Button inputs and lamp/status outputs of the phase scheduler.
interface traffic_phase_scheduler_if;
  logic [3:0] btn;
  logic       ns_r;
  logic       ns_g;
  logic       ew_r;
  logic       ew_g;
  logic       walk_a;
  logic       walk_b;
  logic [2:0] phase;
  logic [7:0] remain;
  logic [3:0] led;

  modport master (output btn,
                  input  ns_r, ns_g, ew_r, ew_g, walk_a, walk_b, phase, remain, led);
  modport slave  (input  btn,
                  output ns_r, ns_g, ew_r, ew_g, walk_a, walk_b, phase, remain, led);
endinterface

// File: rtl/traffic_phase_scheduler_tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks.
module tick_prescaler #(
  parameter int TICK_DIV = 100000000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [W-1:0] cnt_q;

  assign tick = (cnt_q == W'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt_q <= '0;
    else if (tick) cnt_q <= '0;
    else           cnt_q <= cnt_q + W'(1);
  end
endmodule

// File: rtl/traffic_phase_scheduler.sv
// Two-road intersection sequencer with pedestrian walk arbitration and
// button-adjustable green time.
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int TICK_DIV  = DEF_TICK_DIV,
  parameter int G_DEF     = DEF_G_TIME,
  parameter int G_MIN     = DEF_G_MIN,
  parameter int G_MAX     = DEF_G_MAX,
  parameter int STEP      = DEF_STEP,
  parameter int Y_TIME    = DEF_Y_TIME,
  parameter int AR_TIME   = DEF_AR_TIME,
  parameter int WALK_TIME = DEF_WALK_TIME
) (
  input  logic                       clk,
  input  logic                       rst,
  traffic_phase_scheduler_if.slave   bus
);
  localparam logic signed [8:0] STEP_S  = 9'(STEP);
  localparam logic signed [8:0] G_MAX_S = 9'(G_MAX);
  localparam logic signed [8:0] G_MIN_S = 9'(G_MIN);

  logic tick;

  phase_t     state_q, state_d;
  logic [7:0] remain_q, remain_d;
  logic [7:0] g_time_q, g_time_d;
  logic       pend_a_q, pend_a_d, pend_b_q, pend_b_d;
  logic       clr_a, clr_b;
  ped_t       rr_q, rr_d, grant_q, grant_d;
  dir_t       next_dir_q, next_dir_d;
  logic [3:0] btn_q;
  logic [3:0] rise;
  lamps_t     lamps_q, lamps_d;
  logic signed [8:0] g_up, g_dn;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign rise = bus.btn & ~btn_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= NS_GREEN;
      remain_q   <= 8'(G_DEF);
      g_time_q   <= 8'(G_DEF);
      pend_a_q   <= 1'b0;
      pend_b_q   <= 1'b0;
      rr_q       <= A;
      grant_q    <= A;
      next_dir_q <= EW;
      btn_q      <= '0;
      lamps_q    <= LAMPS_RST;
    end else begin
      state_q    <= state_d;
      remain_q   <= remain_d;
      g_time_q   <= g_time_d;
      pend_a_q   <= pend_a_d;
      pend_b_q   <= pend_b_d;
      rr_q       <= rr_d;
      grant_q    <= grant_d;
      next_dir_q <= next_dir_d;
      btn_q      <= bus.btn;
      lamps_q    <= lamps_d;
    end
  end

  always_comb begin
    g_up     = $signed({1'b0, g_time_q}) + STEP_S;
    g_dn     = $signed({1'b0, g_time_q}) - STEP_S;
    g_time_d = g_time_q;
    if (rise[3] && !rise[2])
      g_time_d = (g_up > G_MAX_S) ? G_MAX_S[7:0] : g_up[7:0];
    else if (rise[2] && !rise[3])
      g_time_d = (g_dn < G_MIN_S) ? G_MIN_S[7:0] : g_dn[7:0];
  end

  always_comb begin
    state_d    = state_q;
    remain_d   = remain_q;
    rr_d       = rr_q;
    grant_d    = grant_q;
    next_dir_d = next_dir_q;
    clr_a      = 1'b0;
    clr_b      = 1'b0;
    if (tick) begin
      if (remain_q > 8'd1) begin
        remain_d = remain_q - 8'd1;
      end else begin
        case (state_q)
          NS_GREEN:  begin state_d = NS_YELLOW; remain_d = 8'(Y_TIME); end
          NS_YELLOW: begin state_d = ALL_RED1; remain_d = 8'(AR_TIME); next_dir_d = EW; end
          EW_GREEN:  begin state_d = EW_YELLOW; remain_d = 8'(Y_TIME); end
          EW_YELLOW: begin state_d = ALL_RED2; remain_d = 8'(AR_TIME); next_dir_d = NS; end
          ALL_RED1, ALL_RED2: begin
            // Round-robin pointer always moves past whoever was just served.
            if (pend_a_q && (!pend_b_q || rr_q == A)) begin
              state_d = PED_WALK; remain_d = 8'(WALK_TIME);
              grant_d = A; rr_d = B; clr_a = 1'b1;
            end else if (pend_b_q) begin
              state_d = PED_WALK; remain_d = 8'(WALK_TIME);
              grant_d = B; rr_d = A; clr_b = 1'b1;
            end else begin
              state_d  = (next_dir_q == EW) ? EW_GREEN : NS_GREEN;
              remain_d = g_time_q;
            end
          end
          PED_WALK: begin
            state_d  = (next_dir_q == EW) ? EW_GREEN : NS_GREEN;
            remain_d = g_time_q;
          end
          default: begin state_d = NS_GREEN; remain_d = g_time_q; end
        endcase
      end
    end
  end

  // Requests arriving while their own walk lamp is lit are dropped.
  assign pend_a_d = clr_a ? 1'b0 : (pend_a_q | (rise[0] & ~lamps_q.walk_a));
  assign pend_b_d = clr_b ? 1'b0 : (pend_b_q | (rise[1] & ~lamps_q.walk_b));
  assign lamps_d  = lamps_for(state_d, grant_d);

  assign bus.ns_r   = lamps_q.ns_r;
  assign bus.ns_g   = lamps_q.ns_g;
  assign bus.ew_r   = lamps_q.ew_r;
  assign bus.ew_g   = lamps_q.ew_g;
  assign bus.walk_a = lamps_q.walk_a;
  assign bus.walk_b = lamps_q.walk_b;
  assign bus.phase  = state_q;
  assign bus.remain = remain_q;
  assign bus.led    = (remain_q > 8'd15) ? 4'hF : remain_q[3:0];

endmodule
